// File: rtl/sec_mem_guard.sv
// Security filter between the L2 memory port and main memory: denies normal-domain
// accesses to a protected address window and counts those denials.
module sec_mem_guard #(
  parameter int           p_opaque_nbits = 8,
  parameter int           abw            = 32,
  parameter int           clw            = 128,
  parameter logic [abw-1:0] p_sec_base   = 32'h0000_8000,
  parameter logic [abw-1:0] p_sec_limit  = 32'h0001_0000,
  parameter int           p_cnt_nbits    = 8
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                domain,
  input  logic [3+p_opaque_nbits+abw+$clog2(clw/8)+clw-1:0]   l2req_msg,
  input  logic                                                l2req_val,
  output logic                                                l2req_rdy,
  output logic [3+p_opaque_nbits+$clog2(clw/8)+clw-1:0]       l2resp_msg,
  output logic                                                l2resp_val,
  input  logic                                                l2resp_rdy,
  output logic                                                insecure,
  output logic [3+p_opaque_nbits+abw+$clog2(clw/8)+clw-1:0]   memreq_msg,
  output logic                                                memreq_val,
  input  logic                                                memreq_rdy,
  input  logic [3+p_opaque_nbits+$clog2(clw/8)+clw-1:0]       memresp_msg,
  input  logic                                                memresp_val,
  output logic                                                memresp_rdy,
  output logic [p_cnt_nbits-1:0]                              viol_count
);

  localparam int LenW  = $clog2(clw/8);
  localparam int ReqW  = 3 + p_opaque_nbits + abw + LenW + clw;
  localparam int RespW = 3 + p_opaque_nbits + LenW + clw;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_RESP,
    S_DENY
  } state_e;

  state_e                   state_q, state_d;
  logic [ReqW-1:0]          req_q;
  logic [RespW-1:0]         resp_q;
  logic [p_cnt_nbits-1:0]   cnt_q;

  logic                     req_xfer, resp_xfer, viol;
  logic [2:0]               in_type;
  logic [p_opaque_nbits-1:0] in_opaque;
  logic [abw-1:0]           in_addr;

  assign in_type   = l2req_msg[ReqW-1 -: 3];
  assign in_opaque = l2req_msg[ReqW-4 -: p_opaque_nbits];
  assign in_addr   = l2req_msg[clw+LenW +: abw];

  // An empty window (limit <= base) can never satisfy both bounds, so nothing is denied.
  assign viol      = !domain && (in_addr >= p_sec_base) && (in_addr < p_sec_limit);
  assign req_xfer  = l2req_val && l2req_rdy;
  assign resp_xfer = memresp_val && memresp_rdy;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d     = state_q;
    l2req_rdy   = 1'b0;
    memreq_val  = 1'b0;
    memresp_rdy = 1'b0;
    l2resp_val  = 1'b0;
    insecure    = 1'b0;
    // Handshake outputs are forced low for as long as reset is held.
    if (reset) begin
      unique case (state_q)
        S_IDLE: begin
          l2req_rdy = 1'b1;
          if (l2req_val) state_d = viol ? S_DENY : S_SEND;
        end
        S_SEND: begin
          memreq_val = 1'b1;
          if (memreq_rdy) state_d = S_WAIT;
        end
        S_WAIT: begin
          memresp_rdy = 1'b1;
          if (memresp_val) state_d = S_RESP;
        end
        S_RESP: begin
          l2resp_val = 1'b1;
          if (l2resp_rdy) state_d = S_IDLE;
        end
        S_DENY: begin
          l2resp_val = 1'b1;
          insecure   = 1'b1;
          if (l2resp_rdy) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (req_xfer && viol && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  // NOTE: message buffers carry no reset; they are only observed behind a valid.
  always_ff @(posedge clk) begin
    if (req_xfer) begin
      req_q <= l2req_msg;
      if (viol) resp_q <= {in_type, in_opaque, {LenW{1'b0}}, {clw{1'b0}}};
    end
    if (resp_xfer) resp_q <= memresp_msg;
  end

  assign memreq_msg = req_q;
  assign l2resp_msg = resp_q;
  assign viol_count = cnt_q;

endmodule
